// File: rtl/q_learning_pkg.sv
// Shared widths, fixed-point type and constants for the Q-learning update datapath.
// Q_UPDATE_SAT_EN selects saturating (defined) or wrapping (undefined) DATA_W reductions.
package q_learning_pkg;

    localparam int STATE_W = 4;
    localparam int ACT_W   = 4;
    localparam int DATA_W  = 16;
    localparam int FRAC_W  = 8;

    typedef logic signed [DATA_W-1:0] q_fixed_t;

    localparam q_fixed_t Q_MAX_POS = 16'h7FFF;
    localparam q_fixed_t Q_MAX_NEG = 16'h8000;
    localparam q_fixed_t Q_ONE     = 16'h0100;

`ifdef Q_UPDATE_SAT_EN
    localparam bit Q_SAT_EN = 1'b1;
`else
    localparam bit Q_SAT_EN = 1'b0;
`endif

endpackage

// File: rtl/q_fx_mul.sv
// Signed fixed-point multiply with floor shift by FRAC_W, reduced to DATA_W bits.
// Reduction saturates when Q_UPDATE_SAT_EN is defined, otherwise wraps.
module q_fx_mul #(
    parameter int DATA_W = q_learning_pkg::DATA_W,
    parameter int FRAC_W = q_learning_pkg::FRAC_W
) (
    input  logic signed [DATA_W-1:0] i_a,
    input  logic signed [DATA_W-1:0] i_b,
    output logic signed [DATA_W-1:0] o_p
);
    import q_learning_pkg::*;

    localparam logic signed [2*DATA_W-1:0] L_MAX = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [2*DATA_W-1:0] L_MIN = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [2*DATA_W-1:0] w_a_ext;
    logic signed [2*DATA_W-1:0] w_b_ext;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [2*DATA_W-1:0] w_shift;
    logic signed [DATA_W-1:0]   w_sat;

    assign w_a_ext = {{DATA_W{i_a[DATA_W-1]}}, i_a};
    assign w_b_ext = {{DATA_W{i_b[DATA_W-1]}}, i_b};
    assign w_prod  = w_a_ext * w_b_ext;
    assign w_shift = w_prod >>> FRAC_W;

    always_comb begin
        w_sat = w_shift[DATA_W-1:0];
        if (w_shift > L_MAX) begin
            w_sat = L_MAX[DATA_W-1:0];
        end else if (w_shift < L_MIN) begin
            w_sat = L_MIN[DATA_W-1:0];
        end
    end

    assign o_p = Q_SAT_EN ? w_sat : w_shift[DATA_W-1:0];

endmodule

// File: rtl/q_update_unit.sv
// Four-stage TD update: Q + alpha*(r + gamma*maxQ - Q), valid/ready with a global stall.
// Q_UPDATE_SAT_EN (see q_learning_pkg) selects saturating instead of wrapping reductions.
module q_update_unit #(
    parameter int STATE_W = q_learning_pkg::STATE_W,
    parameter int ACT_W   = q_learning_pkg::ACT_W,
    parameter int DATA_W  = q_learning_pkg::DATA_W,
    parameter int FRAC_W  = q_learning_pkg::FRAC_W,
    parameter int CNT_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [STATE_W-1:0]       i_in_state,
    input  logic [ACT_W-1:0]         i_in_action,
    input  logic signed [DATA_W-1:0] i_q_sa,
    input  logic signed [DATA_W-1:0] i_q_max,
    input  logic signed [DATA_W-1:0] i_reward,
    input  logic signed [DATA_W-1:0] i_gamma,
    input  logic signed [DATA_W-1:0] i_alpha,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [STATE_W-1:0]       o_out_state,
    output logic [ACT_W-1:0]         o_out_action,
    output logic signed [DATA_W-1:0] o_new_q_value,
    output logic                     o_busy,
    output logic [CNT_W-1:0]         o_update_count
);
    import q_learning_pkg::*;

    localparam logic signed [DATA_W+1:0] L_MAX = {3'b000, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W+1:0] L_MIN = {3'b111, {(DATA_W-1){1'b0}}};

    // Sums are formed two bits wide so the reduction sees the true overflow.
    function automatic logic signed [DATA_W-1:0] f_reduce(input logic signed [DATA_W+1:0] v);
        logic signed [DATA_W-1:0] r;
        r = v[DATA_W-1:0];
        if (Q_SAT_EN) begin
            if (v > L_MAX) begin
                r = L_MAX[DATA_W-1:0];
            end else if (v < L_MIN) begin
                r = L_MIN[DATA_W-1:0];
            end
        end
        return r;
    endfunction

    logic                     w_adv;
    logic signed [DATA_W-1:0] w_p1;
    logic signed [DATA_W-1:0] w_p3;
    logic signed [DATA_W+1:0] w_td_wide;
    logic signed [DATA_W+1:0] w_q_wide;

    logic                     r_v1, r_v2, r_v3, r_v4;
    logic [STATE_W-1:0]       r_st1, r_st2, r_st3, r_st4;
    logic [ACT_W-1:0]         r_act1, r_act2, r_act3, r_act4;
    logic signed [DATA_W-1:0] r_qsa1, r_qsa2, r_qsa3;
    logic signed [DATA_W-1:0] r_alpha1, r_alpha2;
    logic signed [DATA_W-1:0] r_reward1;
    logic signed [DATA_W-1:0] r_p1;
    logic signed [DATA_W-1:0] r_td2;
    logic signed [DATA_W-1:0] r_p3;
    logic signed [DATA_W-1:0] r_q4;
    logic [CNT_W-1:0]         r_count;

    assign w_adv      = !r_v4 || i_out_ready;
    assign o_in_ready = w_adv;

    q_fx_mul #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_mul_s1 (
        .i_a (i_gamma),
        .i_b (i_q_max),
        .o_p (w_p1)
    );

    assign w_td_wide = {{2{r_reward1[DATA_W-1]}}, r_reward1}
                     + {{2{r_p1[DATA_W-1]}}, r_p1}
                     - {{2{r_qsa1[DATA_W-1]}}, r_qsa1};

    q_fx_mul #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_mul_s3 (
        .i_a (r_alpha2),
        .i_b (r_td2),
        .o_p (w_p3)
    );

    assign w_q_wide = {{2{r_qsa3[DATA_W-1]}}, r_qsa3} + {{2{r_p3[DATA_W-1]}}, r_p3};

    // Bubbles advance with the pipe; a stalled output freezes every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_v3      <= 1'b0;
            r_v4      <= 1'b0;
            r_st1     <= '0;
            r_st2     <= '0;
            r_st3     <= '0;
            r_st4     <= '0;
            r_act1    <= '0;
            r_act2    <= '0;
            r_act3    <= '0;
            r_act4    <= '0;
            r_qsa1    <= '0;
            r_qsa2    <= '0;
            r_qsa3    <= '0;
            r_alpha1  <= '0;
            r_alpha2  <= '0;
            r_reward1 <= '0;
            r_p1      <= '0;
            r_td2     <= '0;
            r_p3      <= '0;
            r_q4      <= '0;
        end else if (w_adv) begin
            r_v1      <= i_in_valid;
            r_st1     <= i_in_state;
            r_act1    <= i_in_action;
            r_qsa1    <= i_q_sa;
            r_alpha1  <= i_alpha;
            r_reward1 <= i_reward;
            r_p1      <= w_p1;

            r_v2      <= r_v1;
            r_st2     <= r_st1;
            r_act2    <= r_act1;
            r_qsa2    <= r_qsa1;
            r_alpha2  <= r_alpha1;
            r_td2     <= f_reduce(w_td_wide);

            r_v3      <= r_v2;
            r_st3     <= r_st2;
            r_act3    <= r_act2;
            r_qsa3    <= r_qsa2;
            r_p3      <= w_p3;

            r_v4      <= r_v3;
            r_st4     <= r_st3;
            r_act4    <= r_act3;
            r_q4      <= f_reduce(w_q_wide);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (r_v4 && i_out_ready) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_out_valid    = r_v4;
    assign o_out_state    = r_st4;
    assign o_out_action   = r_act4;
    assign o_new_q_value  = r_q4;
    assign o_busy         = r_v1 || r_v2 || r_v3 || r_v4;
    assign o_update_count = r_count;

endmodule

// File: tb/tb_q_update_unit.sv
// Directed bench for q_update_unit: nominal, saturation/wrap, streaming, backpressure,
// mid-flight reset and bubbles, checked against hand values and a longint model.
module tb_q_update_unit;
    import q_learning_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_state;
    logic [3:0]  in_action;
    logic [15:0] q_sa, q_max, reward, gamma, alpha;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_state;
    logic [3:0]  out_action;
    logic [15:0] new_q_value;
    logic        busy;
    logic [31:0] update_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] exp_q[$];
    logic [3:0]  exp_st[$];
    logic [3:0]  exp_act[$];

    q_update_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_in_valid     (in_valid),
        .o_in_ready     (in_ready),
        .i_in_state     (in_state),
        .i_in_action    (in_action),
        .i_q_sa         (q_sa),
        .i_q_max        (q_max),
        .i_reward       (reward),
        .i_gamma        (gamma),
        .i_alpha        (alpha),
        .o_out_valid    (out_valid),
        .i_out_ready    (out_ready),
        .o_out_state    (out_state),
        .o_out_action   (out_action),
        .o_new_q_value  (new_q_value),
        .o_busy         (busy),
        .o_update_count (update_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input logic [15:0] x);
        return longint'($signed(x));
    endfunction

    function automatic logic [15:0] red(input longint v);
`ifdef Q_UPDATE_SAT_EN
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
`endif
        return v[15:0];
    endfunction

    function automatic logic [15:0] model(input logic [15:0] qs, qm, rw, gm, al);
        longint p1, td, p3;
        p1 = sx(red((sx(gm) * sx(qm)) >>> 8));
        td = sx(red(sx(rw) + p1 - sx(qs)));
        p3 = sx(red((sx(al) * td) >>> 8));
        return red(sx(qs) + p3);
    endfunction

    task automatic drive(input logic v, input logic [3:0] st, input logic [3:0] act,
                         input logic [15:0] qs, input logic [15:0] qm, input logic [15:0] rw,
                         input logic [15:0] gm, input logic [15:0] al);
        in_valid = v; in_state = st; in_action = act;
        q_sa = qs; q_max = qm; reward = rw; gamma = gm; alpha = al;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int n_out, first_out, last_out, prev_out, last_tx, k;
        bit seen;
        logic [15:0] e_sat;

        rst_n = 1'b0;
        out_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_new_q", new_q_value, 0);
        chk("rst_out_state", out_state, 0);
        chk("rst_out_action", out_action, 0);
        chk("rst_count", update_count, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // nominal update
        drive(1, 3, 5, 16'h0000, 16'h0A00, 16'h0100, 16'h00E6, 16'h0080);
        #1 chk("nom_in_ready", in_ready, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        #1 chk("nom_not_yet", out_valid, 0);
        chk("nom_busy", busy, 1);
        tick();
        #1 chk("nom_out_valid", out_valid, 1);
        chk("nom_new_q", new_q_value, 16'h04FE);
        chk("nom_model", new_q_value, model(16'h0000, 16'h0A00, 16'h0100, 16'h00E6, 16'h0080));
        chk("nom_state", out_state, 3);
        chk("nom_action", out_action, 5);
        tick();
        #1 chk("nom_count", update_count, 1);
        chk("nom_drained", out_valid, 0);
        chk("nom_idle", busy, 0);

        // saturation / wrap
        do_reset();
        drive(1, 1, 2, 16'h8000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0100);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick(); tick();
`ifdef Q_UPDATE_SAT_EN
        e_sat = 16'hFFFF;
`else
        e_sat = 16'h7FFF;
`endif
        #1 chk("sat_valid", out_valid, 1);
        chk("sat_new_q", new_q_value, e_sat);
        chk("sat_model", new_q_value, model(16'h8000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0100));
        tick();

        // streaming
        do_reset();
        exp_q.delete(); exp_st.delete(); exp_act.delete();
        n_out = 0; first_out = -1; last_out = -1;
        for (int c = 0; c < 20; c++) begin
            if (c < 8)
                drive(1, 4'(c + 2), 4'(c), 16'(c * 64 - 256), 16'(768 + c * 33),
                      (c % 2 == 1) ? 16'h0080 : 16'hFFC0, 16'h00F0, 16'(64 + c * 8));
            else
                drive(0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            if (c < 8) chk("stream_in_ready", in_ready, 1);
            if (out_valid) begin
                if (exp_q.size() == 0) chk("stream_extra_out", 1, 0);
                else begin
                    chk("stream_new_q", new_q_value, exp_q.pop_front());
                    chk("stream_state", out_state, exp_st.pop_front());
                    chk("stream_action", out_action, exp_act.pop_front());
                end
                if (first_out < 0) first_out = c;
                last_out = c;
                n_out++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(q_sa, q_max, reward, gamma, alpha));
                exp_st.push_back(in_state);
                exp_act.push_back(in_action);
            end
            tick();
        end
        chk("stream_n_out", n_out, 8);
        chk("stream_consecutive", last_out - first_out, 7);
        chk("stream_count", update_count, 8);
        chk("stream_idle", busy, 0);

        // backpressure
        do_reset();
        exp_q.delete(); exp_st.delete(); exp_act.delete();
        n_out = 0; k = 0;
        for (int c = 0; c < 40; c++) begin
            out_ready = (c >= 9);
            if (k < 6)
                drive(1, 4'(k), 4'(15 - k), 16'(k * 100), 16'(1024 - k * 50),
                      16'(k * 32), 16'(256 - k * 16), 16'h0100);
            else
                drive(0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            if (out_valid && exp_q.size() == 0) chk("bp_extra_out", 1, 0);
            else if (out_valid && !out_ready) begin
                chk("bp_in_ready", in_ready, 0);
                chk("bp_hold_q", new_q_value, exp_q[0]);
                chk("bp_hold_state", out_state, exp_st[0]);
            end else if (out_valid && out_ready) begin
                chk("bp_new_q", new_q_value, exp_q.pop_front());
                chk("bp_state", out_state, exp_st.pop_front());
                chk("bp_action", out_action, exp_act.pop_front());
                n_out++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(q_sa, q_max, reward, gamma, alpha));
                exp_st.push_back(in_state);
                exp_act.push_back(in_action);
                k++;
            end
            tick();
        end
        chk("bp_n_out", n_out, 6);
        chk("bp_count", update_count, 6);
        chk("bp_idle", busy, 0);

        // reset with entries in flight
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(1, 4'(c), 4'(c), 16'h0100, 16'h0200, 16'h0040, 16'h0100, 16'h0080);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("mid_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_out_valid", out_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_count", update_count, 0);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("mid_no_output", seen, 0);

        // bubbles
        do_reset();
        n_out = 0; prev_out = -1; last_tx = -100;
        for (int c = 0; c < 16; c++) begin
            drive((c < 8) && (c % 2 == 0), 4'(c), 4'(c), 16'h0100, 16'h0200, 16'h0000,
                  16'h0100, 16'h0100);
            #1;
            if (out_valid) begin
                chk("bub_new_q", new_q_value, 16'h0200);
                if (prev_out >= 0) chk("bub_spacing", c - prev_out, 2);
                prev_out = c;
                n_out++;
            end
            if (c == last_tx + 4) chk("bub_busy_last", busy, 1);
            if (c == last_tx + 5) chk("bub_busy_clear", busy, 0);
            if (in_valid && in_ready) last_tx = c;
            tick();
        end
        chk("bub_n_out", n_out, 4);
        chk("bub_count", update_count, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
